// File: rtl/mem_port_arbiter_pkg.sv
// ---------------------------------------------------------------------------
// mem_port_arbiter_pkg
//
// Pipeline-wide definitions shared by the unified memory port arbiter:
//   - arb_state_t : arbiter FSM states (IDLE, BUSY_I, BUSY_D, RESP)
//   - default widths, starvation limit and watchdog timeout
//   - cnt_width() : width helper for small saturating counters
// ---------------------------------------------------------------------------
package mem_port_arbiter_pkg;

    // IDLE   : arbitration happens here and only here
    // BUSY_I : instruction fetch on the port, waiting for mem_ready
    // BUSY_D : data load/store on the port, waiting for mem_ready
    // RESP   : one-cycle response slot, always followed by IDLE
    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        BUSY_I = 2'd1,
        BUSY_D = 2'd2,
        RESP   = 2'd3
    } arb_state_t;

    localparam int DEFAULT_ADDR_W     = 32;
    localparam int DEFAULT_DATA_W     = 32;
    localparam int DEFAULT_STARVE_MAX = 4;
    localparam int DEFAULT_TIMEOUT    = 64;

    // Bits needed to hold values 0..max_val (never less than one bit).
    function automatic int cnt_width(input int max_val);
        int w;
        w = $clog2(max_val + 1);
        if (w < 1) begin
            w = 1;
        end
        return w;
    endfunction

endpackage : mem_port_arbiter_pkg

// File: rtl/mem_port_arbiter.sv
// ---------------------------------------------------------------------------
// mem_port_arbiter
//
// Shares the single unified memory port between the IF stage (read-only
// instruction fetch) and the MEM stage (loads/stores) of the 5-stage pipeline.
// Accesses are serialised: IDLE -> BUSY_x -> RESP -> IDLE, so the peak rate
// is one access every three cycles. Data wins arbitration unless fetch has
// been passed over STARVE_MAX times in a row while waiting. A fetch that is
// flushed still completes on the port but its response is dropped. A watchdog
// abandons an access that sees no mem_ready for TIMEOUT cycles.
//
// Ports:
//   clock, reset            rising-edge clock, synchronous active-high reset
//   if_req/if_addr          fetch request (held until if_valid) and address
//   if_rdata/if_valid       fetched instruction and its one-cycle pulse
//   if_stall                fetch still outstanding (combinational)
//   dm_req/dm_we/dm_be      data request (held until dm_valid), store flag,
//   dm_addr/dm_wdata        byte enables, address and store data
//   dm_rdata/dm_valid       load data and one-cycle pulse (loads and stores)
//   dm_stall                data access still outstanding (combinational)
//   flush                   branch/jump flush from hazard logic
//   mem_req                 port request, held until mem_ready
//   mem_we/mem_be/          latched request fields, stable for the whole
//   mem_addr/mem_wdata      BUSY state
//   mem_ready/mem_rdata     port handshake and read data
//   timeout_err             one-cycle pulse when the watchdog aborts
// ---------------------------------------------------------------------------
module mem_port_arbiter
    import mem_port_arbiter_pkg::*;
#(
    parameter int ADDR_W     = DEFAULT_ADDR_W,
    parameter int DATA_W     = DEFAULT_DATA_W,
    parameter int STARVE_MAX = DEFAULT_STARVE_MAX,
    parameter int TIMEOUT    = DEFAULT_TIMEOUT
) (
    input  logic                clock,
    input  logic                reset,

    input  logic                if_req,
    input  logic [ADDR_W-1:0]   if_addr,
    output logic [DATA_W-1:0]   if_rdata,
    output logic                if_valid,
    output logic                if_stall,

    input  logic                dm_req,
    input  logic                dm_we,
    input  logic [DATA_W/8-1:0] dm_be,
    input  logic [ADDR_W-1:0]   dm_addr,
    input  logic [DATA_W-1:0]   dm_wdata,
    output logic [DATA_W-1:0]   dm_rdata,
    output logic                dm_valid,
    output logic                dm_stall,

    input  logic                flush,

    output logic                mem_req,
    output logic                mem_we,
    output logic [DATA_W/8-1:0] mem_be,
    output logic [ADDR_W-1:0]   mem_addr,
    output logic [DATA_W-1:0]   mem_wdata,
    input  logic                mem_ready,
    input  logic [DATA_W-1:0]   mem_rdata,

    output logic                timeout_err
);

    localparam int BE_W = DATA_W / 8;
    localparam int SC_W = cnt_width(STARVE_MAX);
    localparam int WD_W = cnt_width(TIMEOUT);

    localparam logic [SC_W-1:0] STARVE_LIM = SC_W'(STARVE_MAX);
    localparam logic [WD_W-1:0] WDOG_LAST  = WD_W'(TIMEOUT - 1);

    arb_state_t          state_q,       state_d;
    logic [SC_W-1:0]     starve_cnt_q,  starve_cnt_d;
    logic [WD_W-1:0]     wdog_q,        wdog_d;
    logic                drop_q,        drop_d;
    logic                resp_data_q,   resp_data_d;
    logic                timeout_q,     timeout_d;
    logic                mem_we_q,      mem_we_d;
    logic [BE_W-1:0]     mem_be_q,      mem_be_d;
    logic [ADDR_W-1:0]   mem_addr_q,    mem_addr_d;
    logic [DATA_W-1:0]   mem_wdata_q,   mem_wdata_d;
    logic [DATA_W-1:0]   if_rdata_q,    if_rdata_d;
    logic [DATA_W-1:0]   dm_rdata_q,    dm_rdata_d;

    logic                force_fetch;
    logic                drop_now;

    // Fetch is forced once it has watched STARVE_MAX data grants go by.
    assign force_fetch = if_req && (starve_cnt_q == STARVE_LIM);

    // -----------------------------------------------------------------------
    // Next-state logic. Arbitration and field latching only happen in IDLE;
    // RESP never arbitrates so a requester still holding its request for the
    // response cycle cannot be granted twice.
    // -----------------------------------------------------------------------
    always_comb begin
        state_d      = state_q;
        starve_cnt_d = starve_cnt_q;
        wdog_d       = wdog_q;
        drop_d       = drop_q;
        resp_data_d  = resp_data_q;
        timeout_d    = 1'b0;
        mem_we_d     = mem_we_q;
        mem_be_d     = mem_be_q;
        mem_addr_d   = mem_addr_q;
        mem_wdata_d  = mem_wdata_q;
        if_rdata_d   = if_rdata_q;
        dm_rdata_d   = dm_rdata_q;

        case (state_q)
            IDLE: begin
                drop_d = 1'b0;
                if (dm_req && !force_fetch) begin
                    state_d     = BUSY_D;
                    resp_data_d = 1'b1;
                    mem_we_d    = dm_we;
                    mem_be_d    = dm_be;
                    mem_addr_d  = dm_addr;
                    mem_wdata_d = dm_wdata;
                    // Only data grants that make a waiting fetch wait longer
                    // count towards starvation.
                    if (if_req) begin
                        if (starve_cnt_q != STARVE_LIM) begin
                            starve_cnt_d = starve_cnt_q + SC_W'(1);
                        end
                    end else begin
                        starve_cnt_d = '0;
                    end
                end else if (if_req) begin
                    state_d      = BUSY_I;
                    resp_data_d  = 1'b0;
                    mem_we_d     = 1'b0;
                    mem_be_d     = '1;
                    mem_addr_d   = if_addr;
                    mem_wdata_d  = '0;
                    starve_cnt_d = '0;
                end else begin
                    starve_cnt_d = '0;
                end
            end

            BUSY_I, BUSY_D: begin
                // A flushed fetch keeps its handshake; only the response goes.
                if ((state_q == BUSY_I) && flush) begin
                    drop_d = 1'b1;
                end
                if (mem_ready) begin
                    state_d = RESP;
                    if (state_q == BUSY_I) begin
                        if_rdata_d = mem_rdata;
                    end else begin
                        dm_rdata_d = mem_rdata;
                    end
                end else if (wdog_q == WDOG_LAST) begin
                    // Abandon the access; the requester stays stalled and is
                    // simply re-arbitrated from IDLE.
                    state_d   = IDLE;
                    timeout_d = 1'b1;
                    drop_d    = 1'b0;
                end else begin
                    wdog_d = wdog_q + WD_W'(1);
                end
            end

            RESP: begin
                state_d = IDLE;
                drop_d  = 1'b0;
            end

            default: begin
                state_d = IDLE;
            end
        endcase

        // The watchdog measures time spent in one BUSY state only.
        if (state_d != state_q) begin
            wdog_d = '0;
        end
    end

    // -----------------------------------------------------------------------
    // State and datapath registers. Reset abandons any access in flight
    // without producing a response.
    // -----------------------------------------------------------------------
    always_ff @(posedge clock) begin
        if (reset) begin
            state_q      <= IDLE;
            starve_cnt_q <= '0;
            wdog_q       <= '0;
            drop_q       <= 1'b0;
            resp_data_q  <= 1'b0;
            timeout_q    <= 1'b0;
            mem_we_q     <= 1'b0;
            mem_be_q     <= '0;
            mem_addr_q   <= '0;
            mem_wdata_q  <= '0;
            if_rdata_q   <= '0;
            dm_rdata_q   <= '0;
        end else begin
            state_q      <= state_d;
            starve_cnt_q <= starve_cnt_d;
            wdog_q       <= wdog_d;
            drop_q       <= drop_d;
            resp_data_q  <= resp_data_d;
            timeout_q    <= timeout_d;
            mem_we_q     <= mem_we_d;
            mem_be_q     <= mem_be_d;
            mem_addr_q   <= mem_addr_d;
            mem_wdata_q  <= mem_wdata_d;
            if_rdata_q   <= if_rdata_d;
            dm_rdata_q   <= dm_rdata_d;
        end
    end

    // A flush arriving in the fetch response cycle itself also suppresses
    // the pulse, since the instruction belongs to the squashed path.
    assign drop_now = drop_q || flush;

    assign mem_req     = (state_q == BUSY_I) || (state_q == BUSY_D);
    assign mem_we      = mem_we_q;
    assign mem_be      = mem_be_q;
    assign mem_addr    = mem_addr_q;
    assign mem_wdata   = mem_wdata_q;

    assign if_valid    = (state_q == RESP) && !resp_data_q && !drop_now;
    assign dm_valid    = (state_q == RESP) &&  resp_data_q;
    assign if_rdata    = if_rdata_q;
    assign dm_rdata    = dm_rdata_q;

    assign if_stall    = if_req && !if_valid;
    assign dm_stall    = dm_req && !dm_valid;

    assign timeout_err = timeout_q;

endmodule : mem_port_arbiter

// File: tb/tb_mem_port_arbiter.sv
// ---------------------------------------------------------------------------
// tb_mem_port_arbiter
//
// Drives mem_port_arbiter (STARVE_MAX=4, TIMEOUT=8) with directed scenarios
// followed by randomized traffic, and compares every output every cycle with
// a transaction-level reference model of the port owner.
// ---------------------------------------------------------------------------
module tb_mem_port_arbiter;

    localparam int ADDR_W     = 32;
    localparam int DATA_W     = 32;
    localparam int STARVE_MAX = 4;
    localparam int TIMEOUT    = 8;

    logic        clock = 1'b0;
    logic        reset = 1'b1;
    logic        if_req = 1'b0;
    logic [31:0] if_addr = '0;
    logic [31:0] if_rdata;
    logic        if_valid, if_stall;
    logic        dm_req = 1'b0;
    logic        dm_we = 1'b0;
    logic [3:0]  dm_be = '0;
    logic [31:0] dm_addr = '0;
    logic [31:0] dm_wdata = '0;
    logic [31:0] dm_rdata;
    logic        dm_valid, dm_stall;
    logic        flush = 1'b0;
    logic        mem_req, mem_we;
    logic [3:0]  mem_be;
    logic [31:0] mem_addr, mem_wdata;
    logic        mem_ready = 1'b0;
    logic [31:0] mem_rdata = '0;
    logic        timeout_err;

    int checks = 0;
    int errors = 0;

    // Reference model: who owns the port, whether we are in the response
    // slot, cycles waited, fetch starvation count and the latched request.
    int          m_owner;      // 0 none, 1 fetch, 2 data
    bit          m_resp;
    int          m_wait;
    int          m_starve;
    bit          m_drop;
    bit          m_to;
    logic        m_we;
    logic [3:0]  m_be;
    logic [31:0] m_addr, m_wdata, m_ird, m_drd;

    bit          e_if_valid, e_dm_valid;

    // Observation counters for the directed scenarios.
    int scen_cyc;
    int cnt_mem_req, cnt_if_valid, cnt_dm_valid, cnt_to;
    int first_if_cyc, first_dm_cyc, dm_before_if;

    mem_port_arbiter #(
        .ADDR_W(ADDR_W), .DATA_W(DATA_W),
        .STARVE_MAX(STARVE_MAX), .TIMEOUT(TIMEOUT)
    ) dut (
        .clock(clock), .reset(reset),
        .if_req(if_req), .if_addr(if_addr), .if_rdata(if_rdata),
        .if_valid(if_valid), .if_stall(if_stall),
        .dm_req(dm_req), .dm_we(dm_we), .dm_be(dm_be), .dm_addr(dm_addr),
        .dm_wdata(dm_wdata), .dm_rdata(dm_rdata), .dm_valid(dm_valid),
        .dm_stall(dm_stall), .flush(flush),
        .mem_req(mem_req), .mem_we(mem_we), .mem_be(mem_be),
        .mem_addr(mem_addr), .mem_wdata(mem_wdata),
        .mem_ready(mem_ready), .mem_rdata(mem_rdata),
        .timeout_err(timeout_err)
    );

    always #5 clock = ~clock;

    task automatic checkOutput(input string tag, input logic [31:0] observed,
                               input logic [31:0] expected);
        checks++;
        if (observed !== expected) begin
            errors++;
            $display("[TB] FAIL %s at %0t: observed=%h expected=%h",
                     tag, $time, observed, expected);
        end
    endtask

    task automatic modelReset();
        m_owner = 0; m_resp = 0; m_wait = 0; m_starve = 0; m_drop = 0;
        m_to = 0; m_we = 0; m_be = '0; m_addr = '0; m_wdata = '0;
        m_ird = '0; m_drd = '0;
    endtask

    task automatic clearCounters();
        scen_cyc = 0; cnt_mem_req = 0; cnt_if_valid = 0; cnt_dm_valid = 0;
        cnt_to = 0; first_if_cyc = -1; first_dm_cyc = -1; dm_before_if = -1;
    endtask

    // Drive one cycle of inputs (just after a rising edge), check every output
    // against the model at the falling edge, then advance the model.
    task automatic applyStimulus(input bit i_req, input logic [31:0] i_addr,
                                 input bit d_req, input bit d_we,
                                 input logic [3:0] d_be, input logic [31:0] d_addr,
                                 input logic [31:0] d_wdata, input bit fl,
                                 input bit rdy, input logic [31:0] rdata,
                                 input bit rst);
        bit e_mem_req;
        if_req = i_req; if_addr = i_addr; dm_req = d_req; dm_we = d_we;
        dm_be = d_be; dm_addr = d_addr; dm_wdata = d_wdata; flush = fl;
        mem_ready = rdy; mem_rdata = rdata; reset = rst;

        @(negedge clock);
        e_mem_req  = (m_owner != 0) && !m_resp;
        e_if_valid = m_resp && (m_owner == 1) && !(m_drop || fl);
        e_dm_valid = m_resp && (m_owner == 2);
        checkOutput("mem_req",     mem_req,     e_mem_req);
        checkOutput("mem_we",      mem_we,      m_we);
        checkOutput("mem_be",      mem_be,      m_be);
        checkOutput("mem_addr",    mem_addr,    m_addr);
        checkOutput("mem_wdata",   mem_wdata,   m_wdata);
        checkOutput("if_valid",    if_valid,    e_if_valid);
        checkOutput("dm_valid",    dm_valid,    e_dm_valid);
        checkOutput("if_stall",    if_stall,    i_req && !e_if_valid);
        checkOutput("dm_stall",    dm_stall,    d_req && !e_dm_valid);
        checkOutput("timeout_err", timeout_err, m_to);
        checkOutput("if_rdata",    if_rdata,    m_ird);
        checkOutput("dm_rdata",    dm_rdata,    m_drd);

        if (mem_req)     cnt_mem_req++;
        if (timeout_err) cnt_to++;
        if (dm_valid) begin
            cnt_dm_valid++;
            if (first_dm_cyc < 0) first_dm_cyc = scen_cyc;
        end
        if (if_valid) begin
            cnt_if_valid++;
            if (first_if_cyc < 0) begin
                first_if_cyc = scen_cyc;
                dm_before_if = cnt_dm_valid;
            end
        end
        scen_cyc++;

        // Advance the model by one clock.
        if (rst) begin
            modelReset();
        end else if (m_resp) begin
            m_owner = 0; m_resp = 0; m_drop = 0; m_wait = 0; m_to = 0;
        end else if (m_owner != 0) begin
            m_to = 0;
            if (m_owner == 1 && fl) m_drop = 1;
            if (rdy) begin
                if (m_owner == 1) m_ird = rdata; else m_drd = rdata;
                m_resp = 1; m_wait = 0;
            end else if (m_wait == TIMEOUT - 1) begin
                m_owner = 0; m_to = 1; m_drop = 0; m_wait = 0;
            end else begin
                m_wait++;
            end
        end else begin
            m_to = 0;
            if (d_req && !(i_req && m_starve == STARVE_MAX)) begin
                m_owner = 2; m_we = d_we; m_be = d_be; m_addr = d_addr;
                m_wdata = d_wdata;
                m_starve = i_req ? ((m_starve < STARVE_MAX) ? m_starve + 1 : m_starve) : 0;
            end else if (i_req) begin
                m_owner = 1; m_we = 0; m_be = 4'hF; m_addr = i_addr;
                m_wdata = '0; m_starve = 0;
            end else begin
                m_starve = 0;
            end
        end

        @(posedge clock);
        #1;
    endtask

    task automatic idleReset();
        applyStimulus(0, '0, 0, 0, '0, '0, '0, 0, 0, '0, 1);
        clearCounters();
    endtask

    initial begin
        bit          ip, dp, ireq_now, dreq_now, fl, rdy, rst;
        logic [31:0] ia, da, dw;
        logic [3:0]  db;
        bit          dwe;
        int          ready_pct;

        modelReset();
        clearCounters();
        reset = 1'b1;
        repeat (2) @(posedge clock);
        #1;

        // Reset state, checked while reset is still held.
        idleReset();

        // Single fetch at 0x100 with mem_ready tied high.
        for (int c = 0; c < 6; c++) begin
            ireq_now = (first_if_cyc < 0);
            applyStimulus(ireq_now, 32'h100, 0, 0, '0, '0, '0, 0, 1,
                          32'h0000_0013 + c, 0);
        end
        checkOutput("fetch_latency", first_if_cyc, 2);
        checkOutput("fetch_count",   cnt_if_valid, 1);

        // Concurrent fetch and load: data first, then the fetch.
        idleReset();
        for (int c = 0; c < 8; c++) begin
            ireq_now = (first_if_cyc < 0);
            dreq_now = (first_dm_cyc < 0);
            applyStimulus(ireq_now, 32'h200, dreq_now, 0, 4'hF, 32'h2000, '0,
                          0, 1, 32'hA000_0000 + c, 0);
        end
        checkOutput("conc_dm_cycle", first_dm_cyc, 2);
        checkOutput("conc_if_cycle", first_if_cyc, 5);

        // Data held continuously while fetch waits: fetch forced after 4.
        idleReset();
        for (int c = 0; c < 20; c++) begin
            ireq_now = (first_if_cyc < 0);
            applyStimulus(ireq_now, 32'h300, 1, 1, 4'h3, 32'h4000 + 4 * c,
                          32'hD000 + c, 0, 1, 32'h5000 + c, 0);
        end
        checkOutput("starve_data_grants", dm_before_if, STARVE_MAX);

        // Flushed fetch with mem_ready delayed: handshake completes, no pulse.
        idleReset();
        for (int c = 0; c < 7; c++) begin
            applyStimulus(c < 4, 32'h400, 0, 0, '0, '0, '0, c == 1, c == 3,
                          32'hBAD0_0000, 0);
        end
        checkOutput("flush_memreq_cycles", cnt_mem_req, 3);
        checkOutput("flush_if_valid",      cnt_if_valid, 0);

        // Watchdog: mem_ready never comes for a load, then it is re-issued.
        idleReset();
        for (int c = 0; c < 10; c++) begin
            applyStimulus(0, '0, 1, 0, 4'hF, 32'h6000, '0, 0, 0, '0, 0);
        end
        checkOutput("wdog_memreq_cycles", cnt_mem_req, TIMEOUT);
        checkOutput("wdog_pulses",        cnt_to, 1);
        checkOutput("wdog_no_valid",      cnt_dm_valid, 0);
        for (int c = 0; c < 6; c++) begin
            applyStimulus(0, '0, cnt_dm_valid == 0, 0, 4'hF, 32'h6000, '0, 0,
                          1, 32'h6666_0000, 0);
        end
        checkOutput("wdog_reissue_valid", cnt_dm_valid, 1);

        // Reset in the middle of a store abandons it.
        idleReset();
        for (int c = 0; c < 6; c++) begin
            applyStimulus(0, '0, c < 2, 1, 4'h5, 32'h7000, 32'h1234_5678, 0,
                          0, '0, c == 2);
            if (c == 2) cnt_mem_req = 0;
        end
        checkOutput("rst_memreq_after", cnt_mem_req, 0);
        checkOutput("rst_no_valid",     cnt_dm_valid, 0);

        // Randomized traffic with requesters that hold until served.
        idleReset();
        ip = 0; dp = 0; ia = '0; da = '0; dw = '0; db = '0; dwe = 0;
        ready_pct = 70;
        for (int c = 0; c < 3000; c++) begin
            if (c % 250 == 0) ready_pct = ($urandom_range(0, 2) == 0) ? 4 : 70;
            if (!ip && $urandom_range(0, 2) == 0) begin
                ip = 1; ia = $urandom & 32'hFFFF_FFFC;
            end
            if (!dp && $urandom_range(0, 2) == 0) begin
                dp = 1; da = $urandom; dw = $urandom; db = 4'($urandom);
                dwe = 1'($urandom);
            end
            fl  = ($urandom_range(0, 9) == 0);
            if (fl && ip) ia = $urandom & 32'hFFFF_FFFC;
            rdy = ($urandom_range(0, 99) < ready_pct);
            rst = ($urandom_range(0, 499) == 0);
            applyStimulus(ip, ia, dp, dwe, db, da, dw, fl, rdy, $urandom, rst);
            if (e_if_valid || rst) ip = 0;
            if (e_dm_valid || rst) dp = 0;
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule : tb_mem_port_arbiter

// File: doc/mem_port_arbiter.md
Name: mem_port_arbiter

Overview:
- Shares the single unified memory port between the IF stage (instruction fetch, read-only) and the MEM stage (data load/store) of the 5-stage RISC-V pipeline.
- Serialises accesses through a small FSM and raises per-requester stall signals, which the hazard logic folds into pc_load / if_id_load.
- Data has priority, with bounded fetch starvation.
- Flushed fetches are completed on the port but their responses are dropped.
- A watchdog aborts hung accesses.

Parameters:
- ADDR_W, 32, address width
- DATA_W, 32, data width (byte enables are DATA_W/8 bits)
- STARVE_MAX, 4, consecutive data grants tolerated while if_req waits before fetch is forced
- TIMEOUT, 64, cycles in a BUSY state without mem_ready before abort

Ports:
- clock  in  1  system clock, rising edge
- reset  in  1  synchronous, active-high
- if_req  in  1  fetch request, held until if_valid
- if_addr  in  ADDR_W  fetch address
- if_rdata  out  DATA_W  fetched instruction, valid with if_valid
- if_valid  out  1  one-cycle fetch response pulse
- if_stall  out  1  fetch not yet served
- dm_req  in  1  data request, held until dm_valid
- dm_we  in  1  1 = store
- dm_be  in  DATA_W/8  store byte enables
- dm_addr  in  ADDR_W  data address
- dm_wdata  in  DATA_W  store data
- dm_rdata  out  DATA_W  load data, valid with dm_valid
- dm_valid  out  1  one-cycle data response pulse (loads and stores)
- dm_stall  out  1  data access not yet served
- flush  in  1  branch/jump flush from the hazard/branch logic
- mem_req  out  1  memory request, held until mem_ready
- mem_we, mem_be, mem_addr, mem_wdata  out  1/DATA_W/8/ADDR_W/DATA_W  latched request fields
- mem_ready  in  1  memory accepts/completes this cycle
- mem_rdata  in  DATA_W  read data, sampled when mem_ready=1
- timeout_err  out  1  one-cycle pulse on watchdog abort

Behaviour:
- Reset:
  - State IDLE.
  - All outputs 0, including mem_req, valid pulses, rdata registers and timeout_err.
  - starve_cnt=0, wdog=0, drop=0.
  - Reset mid-access abandons the access with no response.
- FSM states: IDLE, BUSY_I, BUSY_D, RESP.
- IDLE arbitration:
  - dm_req && !(if_req && starve_cnt==STARVE_MAX) -> BUSY_D.
  - Else if_req -> BUSY_I.
  - Else stay in IDLE.
  - Request fields are latched on the transition.
- BUSY_x:
  - mem_req=1 with the latched fields; fields are stable for the whole state.
  - mem_ready=1 -> capture mem_rdata into the matching rdata register, go to RESP.
- RESP:
  - Exactly one of if_valid/dm_valid =1 for this cycle only.
  - if_valid is suppressed when drop=1.
  - No arbitration in RESP; next state is always IDLE.
  - This prevents re-granting a request the requester is still holding.
- Latency and throughput:
  - Request seen in cycle 0 (IDLE), mem_req in cycle 1.
  - With mem_ready in cycle 1, valid comes in cycle 2.
  - Peak throughput is one access per 3 cycles.
- Stalls (combinational):
  - if_stall = if_req && !if_valid.
  - dm_stall = dm_req && !dm_valid.
- Starvation counter:
  - starve_cnt increments on each BUSY_D grant made while if_req=1, saturating at STARVE_MAX.
  - It clears on any BUSY_I grant and whenever if_req=0 in IDLE.
- Flush:
  - flush in BUSY_I or RESP(instruction) sets drop; drop clears on exit to IDLE.
  - The port transaction still completes; it is never aborted mid-handshake.
  - flush in IDLE or any data state has no effect; data accesses are never dropped.
- Watchdog:
  - wdog counts cycles in BUSY_x and clears on any state change.
  - At wdog==TIMEOUT-1 without mem_ready: mem_req drops next cycle, timeout_err pulses, state -> IDLE, no valid pulse.
  - The requester stays stalled and is re-arbitrated.
  - mem_ready in the same cycle as the timeout takes precedence, so the access completes normally.
- Simultaneous if_req and dm_req with starve_cnt<STARVE_MAX: data wins.

Decomposition:
- Shared package (pipeline-wide): arb_state_t enum (IDLE, BUSY_I, BUSY_D, RESP), plus default STARVE_MAX/TIMEOUT constants.
- No sub-module; the watchdog counter is inline. An optional sat_counter sub-module may serve both starve_cnt and wdog.

Test Plan:
- Single fetch, if_addr=0x100, mem_ready tied 1 -> mem_req in cycle 1 with mem_addr=0x100, if_valid in cycle 2 with rdata=mem_rdata, if_stall high in cycles 0-1.
- Concurrent if_req+dm_req (load, 0x2000) -> data served first (dm_valid cycle 2), fetch granted at cycle 3 IDLE, if_valid cycle 5.
- dm_req held continuously with if_req, STARVE_MAX=4 -> exactly 4 data grants, then a fetch grant, then starve_cnt=0.
- flush asserted during BUSY_I with mem_ready delayed 3 cycles -> mem_req held 3 cycles, no if_valid, FSM back to IDLE.
- mem_ready held 0, TIMEOUT=8 -> mem_req high 8 cycles, timeout_err one pulse, no valid, request re-issued after IDLE.
- reset asserted during BUSY_D store -> next cycle mem_req=0, state IDLE, no dm_valid.
